ring_arbiter: RTL and testbench

RING_ARBITER -- requirements
Module: ring_arbiter

---
 rtl/ring_arbiter.sv | 129 ++++++++++++
 tb/tb_ring_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter.sv
// Round-robin ring arbiter with a per-owner hold limit.
// A one-hot pointer rotates past each grantee; owners holding past MAX_HOLD are revoked.
module ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output logic             timeout
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [N-1:0] ONE       = N'(1);
  localparam logic [7:0]   HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         hold_cnt_q, hold_cnt_d;
  logic [N-1:0]       ptr_q, ptr_d;

  logic [N-1:0]       cand;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 ptr_idx;
  int                 scan_idx;
  logic               issue;
  logic [IDX_W-1:0]   issue_idx;

  // Ring search: scanning from the far end down lets the slot nearest ptr win last.
  always_comb begin
    ptr_idx   = 0;
    scan_idx  = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q[i[IDX_W-1:0]]) ptr_idx = i;
    end
    cand = (state_q == OWNED) ? (req & ~grant_q) : req;
    for (int i = N - 1; i >= 0; i--) begin
      scan_idx = (ptr_idx + i) % N;
      if (cand[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    issue      = 1'b0;
    issue_idx  = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          issue     = 1'b1;
          issue_idx = win_idx;
        end
      end
      OWNED: begin
        if (!req[owner_q]) begin
          if (win_found) begin
            issue     = 1'b1;
            issue_idx = win_idx;
          end else begin
            state_d    = IDLE;
            grant_d    = '0;
            owner_d    = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q < HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end else begin
          // Revocation falls back to re-granting the same owner when nobody else waits.
          timeout_d = 1'b1;
          issue     = 1'b1;
          issue_idx = win_found ? win_idx : owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d    = OWNED;
      grant_d    = ONE << issue_idx;
      owner_d    = issue_idx;
      hold_cnt_d = '0;
      if (issue_idx == IDX_W'(N - 1)) ptr_d = ONE;
      else                            ptr_d = ONE << (issue_idx + 1'b1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= ONE;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = |grant_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_ring_arbiter.sv
// Directed bench for ring_arbiter (N=4, MAX_HOLD=8) with a queue of expected outputs.
module tb_ring_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [3:0] grant;
    logic       to;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;
  int   step_id;

  ring_arbiter #(.N(4), .MAX_HOLD(8)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .req(req),
    .grant(grant),
    .owner(owner),
    .busy(busy),
    .timeout(timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [1:0] onehotIndex(input logic [3:0] g);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = 2'(i);
    return idx;
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty step=%0d observed=none expected=entry", step_id);
    end else begin
      e = sb_q.pop_front();
      checks++;
      assert (grant === e.grant) else begin
        errors++;
        $error("[TB] FAIL grant step=%0d observed=%b expected=%b", step_id, grant, e.grant);
      end
      checks++;
      assert (owner === onehotIndex(e.grant)) else begin
        errors++;
        $error("[TB] FAIL owner step=%0d observed=%0d expected=%0d", step_id, owner, onehotIndex(e.grant));
      end
      checks++;
      assert (busy === (e.grant != 4'b0000)) else begin
        errors++;
        $error("[TB] FAIL busy step=%0d observed=%b expected=%b", step_id, busy, (e.grant != 4'b0000));
      end
      checks++;
      assert (timeout === e.to) else begin
        errors++;
        $error("[TB] FAIL timeout step=%0d observed=%b expected=%b", step_id, timeout, e.to);
      end
    end
  endtask

  // Drive one cycle of inputs, queue what should appear after the edge, then check it.
  task automatic applyStimulus(input logic rst, input logic [3:0] r,
                               input logic [3:0] exp_g, input logic exp_to);
    exp_t e;
    RESET   = rst;
    req     = r;
    e.grant = exp_g;
    e.to    = exp_to;
    sb_q.push_back(e);
    step_id++;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_id = 0;
    RESET   = 1'b1;
    req     = 4'b0000;
    @(negedge CLK);

    // Reset state, and reset winning over live requests
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);

    // Single requester holds for three cycles, then releases to idle
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Fairness: each owner holds two cycles then drops; no idle gap between owners
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b1110, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b1101, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0100, 1'b0);
    applyStimulus(1'b0, 4'b1011, 4'b1000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b1000, 1'b0);
    applyStimulus(1'b0, 4'b0111, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Idle cycles leave the pointer at bit 1, so 1001 goes to requester 3
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1001, 4'b1000, 1'b0);

    // Wrap-around: owner 3 releases to 0; pointer now at bit 1 picks 1 out of 1010
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b1010, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Timeout with a competitor: 0001 for 8 cycles, then 0010 with a timeout pulse
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int s = 1; s <= 8; s++) applyStimulus(1'b0, 4'b0011, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b1);
    applyStimulus(1'b0, 4'b0011, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Lone owner: re-granted on each expiry, hold count restarting each time
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int s = 1; s <= 20; s++)
      applyStimulus(1'b0, 4'b0001, 4'b0001, (s == 9 || s == 17));
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    // Reset in the same cycle a timeout would fire
    applyStimulus(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int s = 1; s <= 8; s++) applyStimulus(1'b0, 4'b0001, 4'b0001, 1'b0);
    applyStimulus(1'b1, 4'b0001, 4'b0000, 1'b0);

    // Reset mid-grant while all request, then the first grant favours requester 0
    applyStimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b1110, 4'b0010, 1'b0);
    applyStimulus(1'b0, 4'b1101, 4'b0100, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0000, 1'b0);
    applyStimulus(1'b0, 4'b1111, 4'b0001, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
